multcyc_ctrl_unit: RTL and testbench

- Parametrised successor to the multicycle MIPS controller FSM; sits between the instruction register (opcode), the ALU zero flag and a variable-latency unified memory, and drives every datapath select and enable.
- Adds over the previous generation:
  - mem_req/mem_ready handshake with a watchdog;
  - BNE and the immediate-logic/compare group;
  - sticky Trap state with a cause code.

---
 rtl/multcyc_ctrl_unit_pkg.sv | 85 ++++++++
 rtl/multcyc_ctrl_unit_imm_dec.sv | 42 ++++
 rtl/multcyc_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_multcyc_ctrl_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multcyc_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// multcyc_ctrl_unit_pkg
// Shared types for the multicycle controller: opcodes, ALU op codes, the
// datapath select encodings, controller states and trap causes.
// Optional feature macro used by the decoder: MULTCYC_LOGIC_IMM_EN.
// ---------------------------------------------------------------------------
package multcyc_ctrl_unit_pkg;

   localparam logic [5:0] OP_RR    = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      ALUOP_ADD  = 4'd0,
      ALUOP_SUB  = 4'd1,
      ALUOP_RR   = 4'd2,
      ALUOP_ADDU = 4'd3,
      ALUOP_AND  = 4'd4,
      ALUOP_OR   = 4'd5,
      ALUOP_XOR  = 4'd6,
      ALUOP_SLT  = 4'd7,
      ALUOP_SLTU = 4'd8,
      ALUOP_LUI  = 4'd9
   } alu_op_t;

   typedef enum logic {ADDR_PC = 1'b0, ADDR_ALUOUT = 1'b1} mem_addr_sel_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JMP    = 2'd2
   } nxt_pc_sel_t;

   typedef enum logic {SRCA_PC = 1'b0, SRCA_RS = 1'b1} alu_srca_sel_t;

   typedef enum logic [1:0] {
      SRCB_RT     = 2'd0,
      SRCB_FOUR   = 2'd1,
      SRCB_IMM    = 2'd2,
      SRCB_BEQIMM = 2'd3
   } alu_srcb_sel_t;

   typedef enum logic {WR_RT = 1'b0, WR_RD = 1'b1} wreg_dst_sel_t;

   typedef enum logic {WB_ALUOUT = 1'b0, WB_MEMDATA = 1'b1} wrbck_data_sel_t;

   typedef enum logic [1:0] {
      CAUSE_NONE        = 2'd0,
      CAUSE_ILLEGAL     = 2'd1,
      CAUSE_MEM_TIMEOUT = 2'd2
   } trap_cause_t;

   typedef enum logic [3:0] {
      ST_FETCH      = 4'd0,
      ST_DECODE     = 4'd1,
      ST_MEMADDR    = 4'd2,
      ST_MEMRD      = 4'd3,
      ST_MEMWR      = 4'd4,
      ST_MEMWRBCK   = 4'd5,
      ST_RREXEC     = 4'd6,
      ST_ALURRWRBCK = 4'd7,
      ST_BRANCH     = 4'd8,
      ST_JMP        = 4'd9,
      ST_IMMEXEC    = 4'd10,
      ST_ALURIWRBCK = 4'd11,
      ST_TRAP       = 4'd12
   } state_t;

   // States that hold mem_req high and wait on mem_ready (watched by the watchdog)
   function automatic logic is_mem_wait(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/multcyc_ctrl_unit_imm_dec.sv
// ---------------------------------------------------------------------------
// multcyc_imm_dec
// Combinational decode of the immediate-ALU opcode group.
// Ports:
//   opcode   in  OPCODE_W  instruction opcode field
//   legal    out 1         opcode belongs to the immediate-ALU group
//   alu_op   out alu_op_t  ALU operation for ImmExec
//   imm_zext out 1         zero-extend imm16
// Macro MULTCYC_LOGIC_IMM_EN enables ANDI/ORI/XORI/SLTI/SLTIU/LUI; without it
// only ADDI/ADDIU are legal and imm_zext is always 0.
// ---------------------------------------------------------------------------
module multcyc_imm_dec
   import multcyc_ctrl_unit_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic                legal,
   output alu_op_t             alu_op,
   output logic                imm_zext
);

   always_comb begin
      legal    = 1'b0;
      alu_op   = ALUOP_ADD;
      imm_zext = 1'b0;
      case (opcode)
         OPCODE_W'(OP_ADDI):  begin legal = 1'b1; alu_op = ALUOP_ADD;  end
         OPCODE_W'(OP_ADDIU): begin legal = 1'b1; alu_op = ALUOP_ADDU; end
`ifdef MULTCYC_LOGIC_IMM_EN
         OPCODE_W'(OP_ANDI):  begin legal = 1'b1; alu_op = ALUOP_AND;  imm_zext = 1'b1; end
         OPCODE_W'(OP_ORI):   begin legal = 1'b1; alu_op = ALUOP_OR;   imm_zext = 1'b1; end
         OPCODE_W'(OP_XORI):  begin legal = 1'b1; alu_op = ALUOP_XOR;  imm_zext = 1'b1; end
         OPCODE_W'(OP_LUI):   begin legal = 1'b1; alu_op = ALUOP_LUI;  imm_zext = 1'b1; end
         OPCODE_W'(OP_SLTI):  begin legal = 1'b1; alu_op = ALUOP_SLT;  end
         OPCODE_W'(OP_SLTIU): begin legal = 1'b1; alu_op = ALUOP_SLTU; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/multcyc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// multcyc_ctrl_unit
// Multicycle MIPS controller FSM with a handshaked variable-latency memory,
// a memory watchdog and a sticky trap state.
// Ports:
//   clk, reset (async, active high)
//   opcode, zero, mem_ready                      inputs from IR / ALU / memory
//   mem_req, mem_we, mem_addr_sel                memory control
//   ir_wr, pc_en, nxt_pc_sel                     IR / PC control
//   alu_srca_sel, alu_srcb_sel, alu_op, imm_zext ALU control
//   reg_wr, wreg_dst_sel, wrbck_data_sel         register file control
//   trap, trap_cause, state_dbg                  status
// Macro MULTCYC_LOGIC_IMM_EN (applied in multcyc_imm_dec) enables the
// immediate logic/compare group.
// ---------------------------------------------------------------------------
module multcyc_ctrl_unit
   import multcyc_ctrl_unit_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                ir_wr,
   output logic                pc_en,
   output logic [1:0]          nxt_pc_sel,
   output logic                alu_srca_sel,
   output logic [1:0]          alu_srcb_sel,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                imm_zext,
   output logic                reg_wr,
   output logic                wreg_dst_sel,
   output logic                wrbck_data_sel,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [3:0]          state_dbg
);

   // A zero MEM_TIMEOUT disables the watchdog; keep the counter 1 bit wide then
   localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit WD_EN = (MEM_TIMEOUT > 0);
   localparam logic [TO_W-1:0] WD_LIMIT = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam logic [OPCODE_W-1:0] OPC_RR  = OPCODE_W'(OP_RR);
   localparam logic [OPCODE_W-1:0] OPC_J   = OPCODE_W'(OP_J);
   localparam logic [OPCODE_W-1:0] OPC_BEQ = OPCODE_W'(OP_BEQ);
   localparam logic [OPCODE_W-1:0] OPC_BNE = OPCODE_W'(OP_BNE);
   localparam logic [OPCODE_W-1:0] OPC_LW  = OPCODE_W'(OP_LW);
   localparam logic [OPCODE_W-1:0] OPC_SW  = OPCODE_W'(OP_SW);

   state_t          state;
   state_t          state_nxt;
   trap_cause_t     cause_q;
   trap_cause_t     cause_nxt;
   logic [TO_W-1:0] wd_cnt;
   logic            wd_expire;
   logic            waiting;

   logic            imm_legal;
   alu_op_t         imm_alu_op;
   logic            imm_zext_dec;

   logic            req_raw;
   logic            we_raw;
   logic            irwr_raw;
   logic            pcen_raw;
   logic            regwr_raw;
   logic            trap_raw;
   mem_addr_sel_t   addr_sel;
   nxt_pc_sel_t     npc_sel;
   alu_srca_sel_t   srca_sel;
   alu_srcb_sel_t   srcb_sel;
   alu_op_t         aop;
   logic            zext;
   wreg_dst_sel_t   wdst_sel;
   wrbck_data_sel_t wsrc_sel;

   multcyc_imm_dec #(.OPCODE_W(OPCODE_W)) u_imm_dec (
      .opcode   (opcode),
      .legal    (imm_legal),
      .alu_op   (imm_alu_op),
      .imm_zext (imm_zext_dec)
   );

   // The current cycle is the MEM_TIMEOUT-th consecutive wait cycle and memory
   // still has not answered; mem_ready in this same cycle takes priority.
   assign waiting   = is_mem_wait(state) && !mem_ready;
   assign wd_expire = WD_EN && waiting && (wd_cnt == WD_LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_FETCH;
         cause_q <= CAUSE_NONE;
         wd_cnt  <= '0;
      end else begin
         state   <= state_nxt;
         cause_q <= cause_nxt;
         if (state_nxt != state)
            wd_cnt <= '0;
         else if (WD_EN && waiting)
            wd_cnt <= wd_cnt + TO_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = cause_q;
      case (state)
         ST_FETCH: begin
            if (mem_ready) begin
               state_nxt = ST_DECODE;
            end else if (wd_expire) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (opcode == OPC_LW || opcode == OPC_SW)
               state_nxt = ST_MEMADDR;
            else if (opcode == OPC_RR)
               state_nxt = ST_RREXEC;
            else if (opcode == OPC_BEQ || opcode == OPC_BNE)
               state_nxt = ST_BRANCH;
            else if (opcode == OPC_J)
               state_nxt = ST_JMP;
            else if (imm_legal)
               state_nxt = ST_IMMEXEC;
            else begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_ILLEGAL;
            end
         end
         ST_MEMADDR: state_nxt = (opcode == OPC_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD: begin
            if (mem_ready) begin
               state_nxt = ST_MEMWRBCK;
            end else if (wd_expire) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_MEMWR: begin
            if (mem_ready) begin
               state_nxt = ST_FETCH;
            end else if (wd_expire) begin
               state_nxt = ST_TRAP;
               cause_nxt = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_RREXEC:  state_nxt = ST_ALURRWRBCK;
         ST_IMMEXEC: state_nxt = ST_ALURIWRBCK;
         ST_MEMWRBCK, ST_ALURRWRBCK, ST_ALURIWRBCK,
         ST_BRANCH, ST_JMP: state_nxt = ST_FETCH;
         ST_TRAP:    state_nxt = ST_TRAP;
         default:    state_nxt = ST_FETCH;
      endcase
   end

   always_comb begin
      req_raw   = 1'b0;
      we_raw    = 1'b0;
      irwr_raw  = 1'b0;
      pcen_raw  = 1'b0;
      regwr_raw = 1'b0;
      trap_raw  = 1'b0;
      addr_sel  = ADDR_PC;
      npc_sel   = PC_PLUS4;
      srca_sel  = SRCA_PC;
      srcb_sel  = SRCB_RT;
      aop       = ALUOP_ADD;
      zext      = 1'b0;
      wdst_sel  = WR_RT;
      wsrc_sel  = WB_ALUOUT;
      case (state)
         ST_FETCH: begin
            req_raw  = 1'b1;
            srcb_sel = SRCB_FOUR;
            irwr_raw = mem_ready;
            pcen_raw = mem_ready;
         end
         ST_DECODE: srcb_sel = SRCB_BEQIMM;
         ST_MEMADDR: begin
            srca_sel = SRCA_RS;
            srcb_sel = SRCB_IMM;
         end
         ST_MEMRD: begin
            req_raw  = 1'b1;
            addr_sel = ADDR_ALUOUT;
         end
         ST_MEMWR: begin
            req_raw  = 1'b1;
            we_raw   = 1'b1;
            addr_sel = ADDR_ALUOUT;
         end
         ST_MEMWRBCK: begin
            regwr_raw = 1'b1;
            wsrc_sel  = WB_MEMDATA;
         end
         ST_RREXEC: begin
            srca_sel = SRCA_RS;
            aop      = ALUOP_RR;
         end
         ST_ALURRWRBCK: begin
            regwr_raw = 1'b1;
            wdst_sel  = WR_RD;
         end
         ST_IMMEXEC: begin
            srca_sel = SRCA_RS;
            srcb_sel = SRCB_IMM;
            aop      = imm_alu_op;
            zext     = imm_zext_dec;
         end
         ST_ALURIWRBCK: regwr_raw = 1'b1;
         ST_BRANCH: begin
            srca_sel = SRCA_RS;
            aop      = ALUOP_SUB;
            npc_sel  = PC_BRANCH;
            pcen_raw = (opcode == OPC_BNE) ? !zero : zero;
         end
         ST_JMP: begin
            npc_sel  = PC_JMP;
            pcen_raw = 1'b1;
         end
         ST_TRAP: trap_raw = 1'b1;
         default: ;
      endcase
   end

   // Reset gates the enables combinationally so an in-flight request drops
   // immediately rather than at the next clock edge.
   assign mem_req        = req_raw   & ~reset;
   assign mem_we         = we_raw    & ~reset;
   assign ir_wr          = irwr_raw  & ~reset;
   assign pc_en          = pcen_raw  & ~reset;
   assign reg_wr         = regwr_raw & ~reset;
   assign trap           = trap_raw  & ~reset;
   assign mem_addr_sel   = addr_sel;
   assign nxt_pc_sel     = npc_sel;
   assign alu_srca_sel   = srca_sel;
   assign alu_srcb_sel   = srcb_sel;
   assign alu_op         = ALUOP_W'(aop);
   assign imm_zext       = zext;
   assign wreg_dst_sel   = wdst_sel;
   assign wrbck_data_sel = wsrc_sel;
   assign trap_cause     = cause_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_multcyc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_multcyc_ctrl_unit
// Self-checking bench for multcyc_ctrl_unit (MEM_TIMEOUT = 4). Honours
// MULTCYC_LOGIC_IMM_EN the same way as the design build.
// ---------------------------------------------------------------------------
module tb_multcyc_ctrl_unit;
   import multcyc_ctrl_unit_pkg::*;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, mem_addr_sel, ir_wr, pc_en;
   logic [1:0] nxt_pc_sel;
   logic       alu_srca_sel;
   logic [1:0] alu_srcb_sel;
   logic [3:0] alu_op;
   logic       imm_zext, reg_wr, wreg_dst_sel, wrbck_data_sel, trap;
   logic [1:0] trap_cause;
   logic [3:0] state_dbg;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   multcyc_ctrl_unit #(.OPCODE_W(6), .ALUOP_W(4), .MEM_TIMEOUT(TMO)) dut (
      .clk            (clk),
      .reset          (reset),
      .opcode         (opcode),
      .zero           (zero),
      .mem_ready      (mem_ready),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr_sel   (mem_addr_sel),
      .ir_wr          (ir_wr),
      .pc_en          (pc_en),
      .nxt_pc_sel     (nxt_pc_sel),
      .alu_srca_sel   (alu_srca_sel),
      .alu_srcb_sel   (alu_srcb_sel),
      .alu_op         (alu_op),
      .imm_zext       (imm_zext),
      .reg_wr         (reg_wr),
      .wreg_dst_sel   (wreg_dst_sel),
      .wrbck_data_sel (wrbck_data_sel),
      .trap           (trap),
      .trap_cause     (trap_cause),
      .state_dbg      (state_dbg)
   );

   // {mem_req, mem_we, ir_wr, pc_en, reg_wr}
   function automatic logic [31:0] en_vec();
      return {27'd0, mem_req, mem_we, ir_wr, pc_en, reg_wr};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs after the falling edge and let outputs settle
   task automatic apply_stimulus(input logic [5:0] opc, input logic rdy, input logic z);
      @(negedge clk);
      opcode    = opc;
      mem_ready = rdy;
      zero      = z;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'b0;
      #1;
      check_output("rst_enables", en_vec(), 32'd0);
      check_output("rst_trap", {31'd0, trap}, 32'd0);
      check_output("rst_cause", {30'd0, trap_cause}, CAUSE_NONE);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      string      name;
      logic [5:0] opc;
      logic       rdy;
      logic       z;
      logic [4:0] en;
      int         npc;
      int         aop;
      int         zx;
      int         wdst;
      int         wsrc;
      logic       tr;
      logic [1:0] cause;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(string nm, logic [5:0] opc, logic rdy, logic z, logic [4:0] en,
                                int npc, int aop, int zx, int wdst, int wsrc,
                                logic tr, logic [1:0] cz);
      vec_t v;
      v.name = nm; v.opc = opc; v.rdy = rdy; v.z = z; v.en = en;
      v.npc = npc; v.aop = aop; v.zx = zx; v.wdst = wdst; v.wsrc = wsrc;
      v.tr = tr; v.cause = cz;
      return v;
   endfunction

   function automatic void add_fetch_decode(string nm, logic [5:0] opc, logic z);
      tbl.push_back(row({nm, "_fetch"}, opc, 1'b1, z, 5'b10110, PC_PLUS4, ALUOP_ADD, -1, -1, -1, 1'b0, CAUSE_NONE));
      tbl.push_back(row({nm, "_decode"}, opc, 1'b0, z, 5'b00000, -1, ALUOP_ADD, -1, -1, -1, 1'b0, CAUSE_NONE));
   endfunction

   // ---------------- random reference model ----------------
   typedef struct {
      logic       rdy;
      logic [4:0] en;
      logic       tr;
      logic [1:0] cause;
   } cyc_t;

   cyc_t plan[$];

   function automatic void push(logic r, logic [4:0] e, logic t, logic [1:0] c);
      cyc_t x;
      x.rdy = r; x.en = e; x.tr = t; x.cause = c;
      plan.push_back(x);
   endfunction

   // One memory access with 'waits' not-ready cycles; returns 1 if it times out
   function automatic bit mem_phase(bit is_fetch, bit we, int waits);
      int n = (waits >= TMO) ? TMO : waits;
      for (int i = 0; i < n; i++)
         push(1'b0, {1'b1, we, 3'b000}, 1'b0, CAUSE_NONE);
      if (waits >= TMO) begin
         push(1'b0, 5'b0, 1'b1, CAUSE_MEM_TIMEOUT);
         push(1'b1, 5'b0, 1'b1, CAUSE_MEM_TIMEOUT);
         return 1'b1;
      end
      push(1'b1, {1'b1, we, is_fetch, is_fetch, 1'b0}, 1'b0, CAUSE_NONE);
      return 1'b0;
   endfunction

   function automatic bit legal_op(logic [5:0] op);
      case (op)
         OP_RR, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return 1'b1;
`ifdef MULTCYC_LOGIC_IMM_EN
         OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic int rand_waits();
      if ($urandom_range(0, 6) == 0) return TMO + int'($urandom_range(0, 1));
      return int'($urandom_range(0, TMO - 1));
   endfunction

   // Build the expected cycle sequence of one instruction; returns 1 if it traps
   function automatic bit build_plan(logic [5:0] op, logic z);
      bit t;
      plan.delete();
      if (mem_phase(1'b1, 1'b0, rand_waits())) return 1'b1;
      push(1'($urandom_range(0, 1)), 5'b0, 1'b0, CAUSE_NONE);
      if (!legal_op(op)) begin
         push(1'b0, 5'b0, 1'b1, CAUSE_ILLEGAL);
         push(1'b1, 5'b0, 1'b1, CAUSE_ILLEGAL);
         return 1'b1;
      end
      case (op)
         OP_LW: begin
            push(1'($urandom_range(0, 1)), 5'b0, 1'b0, CAUSE_NONE);
            t = mem_phase(1'b0, 1'b0, rand_waits());
            if (t) return 1'b1;
            push(1'($urandom_range(0, 1)), 5'b00001, 1'b0, CAUSE_NONE);
         end
         OP_SW: begin
            push(1'($urandom_range(0, 1)), 5'b0, 1'b0, CAUSE_NONE);
            return mem_phase(1'b0, 1'b1, rand_waits());
         end
         OP_BEQ: push(1'($urandom_range(0, 1)), {3'b000, z, 1'b0}, 1'b0, CAUSE_NONE);
         OP_BNE: push(1'($urandom_range(0, 1)), {3'b000, !z, 1'b0}, 1'b0, CAUSE_NONE);
         OP_J:   push(1'($urandom_range(0, 1)), 5'b00010, 1'b0, CAUSE_NONE);
         default: begin
            push(1'($urandom_range(0, 1)), 5'b0, 1'b0, CAUSE_NONE);
            push(1'($urandom_range(0, 1)), 5'b00001, 1'b0, CAUSE_NONE);
         end
      endcase
      return 1'b0;
   endfunction

   logic [5:0] op_pool [14] = '{OP_RR, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                                OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};

   initial begin
      // ---------- power-on reset ----------
      #1 reset = 1'b1;
      #1;
      check_output("por_enables", en_vec(), 32'd0);
      check_output("por_trap", {31'd0, trap}, 32'd0);
      check_output("por_cause", {30'd0, trap_cause}, CAUSE_NONE);
      check_output("por_state", {28'd0, state_dbg}, ST_FETCH);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // ---------- reset asserted mid-Fetch ----------
      apply_stimulus(OP_RR, 1'b0, 1'b0);
      check_output("midfetch_req_before", {31'd0, mem_req}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check_output("midfetch_req_dropped", en_vec(), 32'd0);
      check_output("midfetch_trap", {31'd0, trap}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      apply_stimulus(OP_RR, 1'b0, 1'b0);
      check_output("midfetch_state_after", {28'd0, state_dbg}, ST_FETCH);
      check_output("midfetch_req_after", {31'd0, mem_req}, 32'd1);
      do_reset();

      // ---------- directed table ----------
      add_fetch_decode("add", OP_RR, 1'b0);
      tbl.push_back(row("add_exec", OP_RR, 1'b1, 1'b0, 5'b00000, -1, ALUOP_RR, -1, -1, -1, 1'b0, CAUSE_NONE));
      tbl.push_back(row("add_wrbck", OP_RR, 1'b0, 1'b0, 5'b00001, -1, -1, -1, WR_RD, WB_ALUOUT, 1'b0, CAUSE_NONE));
      add_fetch_decode("bne", OP_BNE, 1'b0);
      tbl.push_back(row("bne_branch", OP_BNE, 1'b0, 1'b0, 5'b00010, PC_BRANCH, ALUOP_SUB, -1, -1, -1, 1'b0, CAUSE_NONE));
      add_fetch_decode("beq0", OP_BEQ, 1'b0);
      tbl.push_back(row("beq0_branch", OP_BEQ, 1'b1, 1'b0, 5'b00000, PC_BRANCH, ALUOP_SUB, -1, -1, -1, 1'b0, CAUSE_NONE));
      add_fetch_decode("beq1", OP_BEQ, 1'b1);
      tbl.push_back(row("beq1_branch", OP_BEQ, 1'b0, 1'b1, 5'b00010, PC_BRANCH, ALUOP_SUB, -1, -1, -1, 1'b0, CAUSE_NONE));
      add_fetch_decode("jmp", OP_J, 1'b0);
      tbl.push_back(row("jmp_exec", OP_J, 1'b0, 1'b0, 5'b00010, PC_JMP, -1, -1, -1, -1, 1'b0, CAUSE_NONE));
      add_fetch_decode("addiu", OP_ADDIU, 1'b0);
      tbl.push_back(row("addiu_exec", OP_ADDIU, 1'b0, 1'b0, 5'b00000, -1, ALUOP_ADDU, 0, -1, -1, 1'b0, CAUSE_NONE));
      tbl.push_back(row("addiu_wrbck", OP_ADDIU, 1'b0, 1'b0, 5'b00001, -1, -1, -1, WR_RT, WB_ALUOUT, 1'b0, CAUSE_NONE));
      add_fetch_decode("ori", OP_ORI, 1'b0);
`ifdef MULTCYC_LOGIC_IMM_EN
      tbl.push_back(row("ori_exec", OP_ORI, 1'b0, 1'b0, 5'b00000, -1, ALUOP_OR, 1, -1, -1, 1'b0, CAUSE_NONE));
      tbl.push_back(row("ori_wrbck", OP_ORI, 1'b0, 1'b0, 5'b00001, -1, -1, -1, WR_RT, WB_ALUOUT, 1'b0, CAUSE_NONE));
`else
      tbl.push_back(row("ori_trap", OP_ORI, 1'b0, 1'b0, 5'b00000, -1, -1, -1, -1, -1, 1'b1, CAUSE_ILLEGAL));
      tbl.push_back(row("ori_trap_sticky", OP_ORI, 1'b1, 1'b0, 5'b00000, -1, -1, -1, -1, -1, 1'b1, CAUSE_ILLEGAL));
`endif
      foreach (tbl[i]) begin
         apply_stimulus(tbl[i].opc, tbl[i].rdy, tbl[i].z);
         check_output({tbl[i].name, "_en"}, en_vec(), {27'd0, tbl[i].en});
         check_output({tbl[i].name, "_trap"}, {31'd0, trap}, {31'd0, tbl[i].tr});
         check_output({tbl[i].name, "_cause"}, {30'd0, trap_cause}, {30'd0, tbl[i].cause});
         if (tbl[i].npc >= 0)  check_output({tbl[i].name, "_npc"}, {30'd0, nxt_pc_sel}, tbl[i].npc);
         if (tbl[i].aop >= 0)  check_output({tbl[i].name, "_aluop"}, {28'd0, alu_op}, tbl[i].aop);
         if (tbl[i].zx >= 0)   check_output({tbl[i].name, "_zext"}, {31'd0, imm_zext}, tbl[i].zx);
         if (tbl[i].wdst >= 0) check_output({tbl[i].name, "_wdst"}, {31'd0, wreg_dst_sel}, tbl[i].wdst);
         if (tbl[i].wsrc >= 0) check_output({tbl[i].name, "_wsrc"}, {31'd0, wrbck_data_sel}, tbl[i].wsrc);
      end
      do_reset();

      // ---------- LW with 3 wait cycles on Fetch and on MemRd ----------
      for (int c = 1; c <= 11; c++) begin
         apply_stimulus(OP_LW, (c == 4) || (c == 10), 1'b0);
         check_output($sformatf("lw_c%0d_req", c), {31'd0, mem_req},
                      {31'd0, (c <= 4) || (c >= 7 && c <= 10)});
         check_output($sformatf("lw_c%0d_regwr", c), {31'd0, reg_wr}, {31'd0, c == 11});
         if (c >= 7 && c <= 10)
            check_output($sformatf("lw_c%0d_addr", c), {31'd0, mem_addr_sel}, ADDR_ALUOUT);
         if (c == 11) begin
            check_output("lw_wsrc", {31'd0, wrbck_data_sel}, WB_MEMDATA);
            check_output("lw_wdst", {31'd0, wreg_dst_sel}, WR_RT);
         end
      end
      do_reset();

      // ---------- opcode 0x3F is illegal in every build ----------
      apply_stimulus(6'h3F, 1'b1, 1'b0);
      apply_stimulus(6'h3F, 1'b0, 1'b0);
      apply_stimulus(6'h3F, 1'b0, 1'b0);
      check_output("op3f_trap", {31'd0, trap}, 32'd1);
      check_output("op3f_cause", {30'd0, trap_cause}, CAUSE_ILLEGAL);
      check_output("op3f_enables", en_vec(), 32'd0);
      do_reset();

      // ---------- MemWr timeout: ready never comes ----------
      apply_stimulus(OP_SW, 1'b1, 1'b0);
      apply_stimulus(OP_SW, 1'b0, 1'b0);
      apply_stimulus(OP_SW, 1'b0, 1'b0);
      for (int w = 1; w <= TMO; w++) begin
         apply_stimulus(OP_SW, 1'b0, 1'b0);
         check_output($sformatf("swto_w%0d_req_we", w), {30'd0, mem_req, mem_we}, 32'd3);
      end
      apply_stimulus(OP_SW, 1'b0, 1'b0);
      check_output("swto_trap", {31'd0, trap}, 32'd1);
      check_output("swto_cause", {30'd0, trap_cause}, CAUSE_MEM_TIMEOUT);
      check_output("swto_enables", en_vec(), 32'd0);
      do_reset();

      // ---------- MemWr: ready arrives on the last allowed wait cycle ----------
      apply_stimulus(OP_SW, 1'b1, 1'b0);
      apply_stimulus(OP_SW, 1'b0, 1'b0);
      apply_stimulus(OP_SW, 1'b0, 1'b0);
      for (int w = 1; w <= TMO; w++) begin
         apply_stimulus(OP_SW, w == TMO, 1'b0);
         check_output($sformatf("swrace_w%0d_req_we", w), {30'd0, mem_req, mem_we}, 32'd3);
      end
      apply_stimulus(OP_RR, 1'b0, 1'b0);
      check_output("swrace_trap", {31'd0, trap}, 32'd0);
      check_output("swrace_state", {28'd0, state_dbg}, ST_FETCH);
      check_output("swrace_req", {30'd0, mem_req, mem_we}, 32'd2);
      do_reset();

      // ---------- randomized instruction stream ----------
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op;
         logic       z;
         bit         trapped;
         int         k = int'($urandom_range(0, 14));
         op = (k == 14) ? 6'($urandom_range(0, 63)) : op_pool[k];
         z  = 1'($urandom_range(0, 1));
         trapped = build_plan(op, z);
         foreach (plan[i]) begin
            apply_stimulus(op, plan[i].rdy, z);
            check_output($sformatf("rnd%0d_op%0h_c%0d_en", n, op, i), en_vec(), {27'd0, plan[i].en});
            check_output($sformatf("rnd%0d_op%0h_c%0d_trap", n, op, i), {31'd0, trap}, {31'd0, plan[i].tr});
            check_output($sformatf("rnd%0d_op%0h_c%0d_cause", n, op, i), {30'd0, trap_cause},
                         {30'd0, plan[i].cause});
         end
         if (trapped) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
